// File: rtl/rotator_deserializer_if.sv
// Serial-in / parallel-out bus between a bit producer and the deserializer.
interface rotator_deserializer_if #(
    parameter int unsigned WIDTH = 100
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             start;
    logic [1:0]       dir;
    logic             abort;
    logic             sin;
    logic             sin_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic             err;

    // Producer/consumer side: drives frame control and serial data, reads the word.
    modport master (
        output start, dir, abort, sin, sin_valid, out_ready,
        input  q, out_valid, busy, cnt, err
    );

    // Deserializer side.
    modport slave (
        input  start, dir, abort, sin, sin_valid, out_ready,
        output q, out_valid, busy, cnt, err
    );
endinterface

// File: rtl/rotator_deserializer.sv
// Shifts a serial frame into a WIDTH-bit word, LSB-first or MSB-first, and
// holds the completed word until the consumer takes it.
module rotator_deserializer #(
    parameter int unsigned WIDTH = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rotator_deserializer_if.slave bus
);
    localparam int unsigned CW      = $clog2(WIDTH + 1);
    localparam logic [1:0]  DIR_LSB = 2'b01;
    localparam logic [1:0]  DIR_MSB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] q_r, q_d;
    logic [CW-1:0]    cnt_r, cnt_d;
    logic             ov_r, ov_d;
    logic             err_r, err_d;
    logic             busy_r, busy_d;
    logic [1:0]       dir_r, dir_d;
    logic             legal_c;

    assign legal_c = (bus.dir == DIR_LSB) || (bus.dir == DIR_MSB);

    // State and all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q_r    <= '0;
            cnt_r  <= '0;
            ov_r   <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b0;
            dir_r  <= DIR_LSB;
        end else begin
            state  <= state_d;
            q_r    <= q_d;
            cnt_r  <= cnt_d;
            ov_r   <= ov_d;
            err_r  <= err_d;
            busy_r <= busy_d;
            dir_r  <= dir_d;
        end
    end

    // Next state and next register values; abort overrides every other request.
    always_comb begin
        state_d = state;
        q_d     = q_r;
        cnt_d   = cnt_r;
        ov_d    = ov_r;
        err_d   = 1'b0;
        dir_d   = dir_r;

        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            ov_d    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (legal_c) begin
                            dir_d   = bus.dir;
                            cnt_d   = '0;
                            state_d = RECV;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (bus.start && legal_c) begin
                        // Restart: the bit on sin this cycle belongs to no frame.
                        dir_d = bus.dir;
                        cnt_d = '0;
                    end else begin
                        if (bus.start) begin
                            err_d = 1'b1;
                        end
                        if (bus.sin_valid) begin
                            if (dir_r == DIR_LSB) begin
                                q_d = {bus.sin, q_r[WIDTH-1:1]};
                            end else begin
                                q_d = {q_r[WIDTH-2:0], bus.sin};
                            end
                            cnt_d = cnt_r + CW'(1);
                            if (cnt_r == CW'(WIDTH - 1)) begin
                                state_d = FULL;
                                ov_d    = 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (ov_r && bus.out_ready) begin
                        state_d = IDLE;
                        ov_d    = 1'b0;
                        cnt_d   = '0;
                    end else if (bus.sin_valid) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == RECV);
    end

    assign bus.q         = q_r;
    assign bus.cnt       = cnt_r;
    assign bus.out_valid = ov_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: doc/rotator_deserializer.md
ROTATOR_DESERIALIZER -- requirements
Module: rotator_deserializer

Interface
REQ-001 Parameter WIDTH, default 100, parallel word width in bits (legal range 2..128).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  synchronous frame-begin request.
REQ-005 dir  input  2  bit order of the frame, sampled with start: 2'b01 LSB-first (right-rotate emit order), 2'b10 MSB-first (left-rotate emit order), 2'b00/2'b11 illegal.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 sin  input  1  serial data bit.
REQ-008 sin_valid  input  1  sin carries a valid bit this cycle.
REQ-009 out_ready  input  1  consumer accepts q this cycle.
REQ-010 q  output  WIDTH  assembled parallel word, registered.
REQ-011 out_valid  output  1  q holds a complete frame.
REQ-012 busy  output  1  high in RECV.
REQ-013 cnt  output  clog2(WIDTH+1)  bits received in current frame.
REQ-014 err  output  1  one-cycle pulse on illegal dir at start or on bit dropped while FULL.

Function
REQ-015 FSM states IDLE, RECV, FULL; registered outputs only.
REQ-016 IDLE: start with legal dir -> latch dir, cnt<=0, RECV next cycle; start with illegal dir -> stay IDLE, err pulse; sin_valid ignored, no err.
REQ-017 RECV, sin_valid=1, LSB-first: q <= {sin, q[WIDTH-1:1]}, cnt+1; after WIDTH bits the first received bit sits in q[0].
REQ-018 RECV, sin_valid=1, MSB-first: q <= {q[WIDTH-2:0], sin}, cnt+1; after WIDTH bits the first received bit sits in q[WIDTH-1].
REQ-019 RECV, sin_valid=0: q, cnt unchanged (stall, no timeout).
REQ-020 Bit WIDTH accepted (cnt goes WIDTH-1 -> WIDTH) -> FULL, out_valid=1 on the next cycle; latency from last bit to out_valid is one clock.
REQ-021 FULL: q, cnt, out_valid held stable until out_valid&&out_ready; that cycle -> IDLE, out_valid<=0, cnt<=0.
REQ-022 FULL, sin_valid=1 without handshake completing: bit dropped, err pulse, q unchanged.
REQ-023 start in RECV with legal dir: restart frame (cnt<=0, new dir latched, bit on sin that cycle NOT consumed); with illegal dir: err pulse, frame continues.
REQ-024 start in FULL: ignored, no err.
REQ-025 abort in any state: next state IDLE, cnt<=0, out_valid<=0, q retained; abort has priority over start, sin_valid and out_ready in the same cycle.
REQ-026 out_ready while out_valid=0: no effect.
REQ-027 cnt never exceeds WIDTH; no wrap.

Reset
REQ-028 rst_n=0 immediately (no clock needed) forces state IDLE, q=0, out_valid=0, busy=0, cnt=0, err=0, latched dir=2'b01.
REQ-029 Reset deasserted mid-frame discards all partial data; first frame after reset requires a new start.

Verification
REQ-030 WIDTH=8, start dir=01, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_valid one clock after 8th bit, q=8'h4D, cnt=8.
REQ-031 WIDTH=8, start dir=10, same bit sequence with sin_valid low every other cycle -> q=8'hB2, out_valid held with out_ready=0 for 5 cycles, clears the cycle after out_ready=1.
REQ-032 WIDTH=8, start dir=11 -> err pulse 1 cycle, busy stays 0; in FULL drive sin_valid=1 -> err pulse, q unchanged.
REQ-033 WIDTH=8, abort and start asserted together after 3 bits -> IDLE, cnt=0, busy=0, q retains the 3-bit partial value.
REQ-034 WIDTH=100, dir=01, 100 bits alternating 1,0 -> q=all 5s pattern (100'h5...5), cnt=100; assert rst_n=0 mid-next-frame -> all outputs 0 asynchronously.
